sif_address_rx: RTL and testbench
=================================

# sif_address_rx

Receive end of the SIF address link. It samples the serial clock/data pair driven by the SIF address transmitter, which sends a 12-bit frame of tx_add_1, tx_add_2 and rx_add, 4 bits each. It reassembles the three address fields and raises a one-cycle valid strobe per complete frame. It flags frames addressed to this node and reports frames that stall mid-transfer.

## Interface
- MY_ADDR, 4'b1010, this node's address, compared against the received rx_add field
- TIMEOUT, 64, clk_i cycles allowed between consecutive spi_clk_i rising edges inside a frame (range 4..1023)
- clk_i  input  1  system clock, 100 MHz
- rst_i  input  1  asynchronous, active-low reset
- spi_clk_i  input  1  serial clock from transmitter, asynchronous to clk_i
- spi_data_i  input  1  serial data, stable around each spi_clk_i rising edge
- mode_i  input  1  bit order per field: 0 = MSB first, 1 = LSB first
- tx_add_1_o  output  4  first received field
- tx_add_2_o  output  4  second received field
- rx_add_o  output  4  third received field
- valid_o  output  1  one-cycle strobe, fields updated
- match_o  output  1  rx_add_o == MY_ADDR, updated with valid_o
- busy_o  output  1  frame in progress
- err_o  output  1  one-cycle strobe, frame aborted by timeout

## Operation
- spi_clk_i and spi_data_i each pass through a 2-flop synchronizer.
- A third flop on the clock path holds the previous value. rise = sync2 & ~prev.
- State machine with two states:
  - IDLE: bit_cnt=0, timer=0. On rise: shift in bit 0, latch mode_i into mode_q, go to RECV.
  - RECV: on rise, shift in a bit and increment bit_cnt. The timer clears on each rise and increments otherwise.
  - RECV, 12th bit: load the output fields, pulse valid_o, go to IDLE.
  - RECV, timer reaches TIMEOUT-1 without a rise: pulse err_o, discard partial data, go to IDLE. Output fields stay unchanged.
- Frame order on the wire: tx_add_1, then tx_add_2, then rx_add.
- Field bit order: mode_q=0 means the first bit of each field is bit[3]; mode_q=1 means it is bit[0].
- mode_i is sampled only on the first bit of a frame. Changes mid-frame are ignored.
- busy_o = (state == RECV).
- Output fields and match_o hold their values until the next valid frame.
- A rise and a timer expiry in the same cycle: the rise wins and no error is raised.
- Reset asserted mid-frame: the partial frame is lost. After release the block is in IDLE and waits for a fresh first bit.
- Back-to-back frames: a rise in the cycle after valid_o starts a new frame normally.

## Timing
- Reset values: tx_add_1_o=0, tx_add_2_o=0, rx_add_o=0, valid_o=0, match_o=0, busy_o=0, err_o=0. State=IDLE, synchronizers=0.
- Input requirements:
  - spi_clk_i high and low phases each last at least 2 clk_i cycles.
  - spi_data_i is stable from 1 clk_i cycle before to 3 clk_i cycles after each spi_clk_i rising edge.
- A pin-level spi_clk_i rise is shifted in on the 3rd clk_i rising edge after it is stable.
- valid_o and the updated fields/match_o appear on that same edge for the 12th bit. valid_o is high for exactly 1 cycle.
- busy_o rises on the edge that shifts bit 0. It falls on the edge that asserts valid_o or err_o.
- err_o asserts TIMEOUT cycles after the last shifted rise and is high for 1 cycle.
- Throughput: one frame per 12 spi_clk_i periods. There is no dead time between frames.

## Test plan
- Reset: drive rst_i=0 mid-idle, then release with spi_clk_i=0. All outputs must be 0. Then send mode 0 frame 0000/1111/1010: tx_add_1_o=0, tx_add_2_o=F, rx_add_o=A, match_o=1, one valid_o pulse, busy_o high for the whole frame.
- Bit order: mode_i=1, send wire bits 1000 0111 1010 (LSB first). Expect tx_add_1_o=1, tx_add_2_o=E, rx_add_o=5, match_o=0. Toggle mode_i mid-frame: result is unchanged.
- Timeout: send 7 bits, then hold spi_clk_i low. err_o must pulse exactly 64 cycles after the 7th shifted rise, busy_o must drop, the outputs must keep the previous frame, and valid_o must not pulse. A following full frame 0011/1100/0110 must decode to 3/C/6.
- Edge race: with TIMEOUT=4, place a rise on the 3rd idle cycle after the previous shifted rise, so the rise and expiry coincide. The frame must continue with no err_o.
- Reset mid-frame: assert rst_i after 5 bits, then send a full frame 0100/1000/1100. Decode must be 4/8/C with exactly one valid_o pulse.
- Back-to-back: stream 7 frames with minimum 2-cycle spi_clk_i phases, using the transmitter vector set (0/0/0, 0/F/A, 1/E/5, 2/D/9, 3/C/6, 4/8/C, 5/7/3). Expect 7 valid_o pulses, all fields correct, match_o high only for 0/F/A.

Source files
------------

// File: rtl/sif_address_rx.sv
// Receive end of the SIF address link: resynchronises the serial clock/data pair,
// reassembles the three 4-bit address fields and flags local-address and stalled frames.
module sif_address_rx #(
    parameter logic [3:0] MY_ADDR = 4'b1010,
    parameter int         TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_clk_i,
    input  logic       spi_data_i,
    input  logic       mode_i,
    output logic [3:0] tx_add_1_o,
    output logic [3:0] tx_add_2_o,
    output logic [3:0] rx_add_o,
    output logic       valid_o,
    output logic       match_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic {S_IDLE, S_RECV} state_t;

    localparam logic [9:0] TMAX = 10'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_clk_s1, r_clk_s2, r_clk_prev;
    logic        r_dat_s1, r_dat_s2;
    logic [10:0] r_shift;
    logic [3:0]  r_bit_cnt;
    logic [9:0]  r_timer;
    logic        r_mode_q;
    logic        w_rise;
    logic        w_last;
    logic        w_timeout;
    logic [11:0] w_frame;
    logic [3:0]  w_rx_field;

    // Wire order puts the first-sent bit of each field in the field's MSB slot;
    // LSB-first mode reverses each nibble back into numeric order.
    function automatic logic [3:0] reorder(input logic [3:0] f, input logic lsb_first);
        return lsb_first ? {f[0], f[1], f[2], f[3]} : f;
    endfunction

    assign w_rise     = r_clk_s2 & ~r_clk_prev;
    assign w_last     = (r_bit_cnt == 4'd11);
    assign w_timeout  = (r_timer == TMAX);
    assign w_frame    = {r_shift, r_dat_s2};
    assign w_rx_field = reorder(w_frame[3:0], r_mode_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_s1   <= 1'b0;
            r_dat_s2   <= 1'b0;
        end else begin
            r_clk_s1   <= spi_clk_i;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= spi_data_i;
            r_dat_s2   <= r_dat_s1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_rise) w_state_next = S_RECV;
            S_RECV: begin
                if (w_rise && w_last)       w_state_next = S_IDLE;
                else if (!w_rise && w_timeout) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == S_RECV);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_timer    <= '0;
            r_mode_q   <= 1'b0;
            tx_add_1_o <= '0;
            tx_add_2_o <= '0;
            rx_add_o   <= '0;
            valid_o    <= 1'b0;
            match_o    <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                r_timer   <= '0;
                if (w_rise) begin
                    r_shift   <= {r_shift[9:0], r_dat_s2};
                    r_bit_cnt <= 4'd1;
                    r_mode_q  <= mode_i;
                end
            end else if (w_rise) begin
                // A rise on the expiry cycle takes priority over the timeout.
                r_shift   <= {r_shift[9:0], r_dat_s2};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_timer   <= '0;
                if (w_last) begin
                    tx_add_1_o <= reorder(w_frame[11:8], r_mode_q);
                    tx_add_2_o <= reorder(w_frame[7:4], r_mode_q);
                    rx_add_o   <= w_rx_field;
                    match_o    <= (w_rx_field == MY_ADDR);
                    valid_o    <= 1'b1;
                    r_bit_cnt  <= '0;
                end
            end else if (w_timeout) begin
                err_o     <= 1'b1;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_timer   <= '0;
            end else begin
                r_timer <= r_timer + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_sif_address_rx.sv
// Scoreboarded bench for sif_address_rx: a TIMEOUT=64 instance for the main tests and a
// TIMEOUT=4 instance streamed at minimum phase length so every rise lands on the expiry cycle.
module tb_sif_address_rx;

    localparam logic [3:0] MY = 4'b1010;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic       m;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sclk, sdat, mode, sclk2, sdat2, mode2;
    logic [3:0] a1, b1, c1, a2, b2, c2;
    logic       val1, mat1, busy1, err1, val2, mat2, busy2, err2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q1[$];
    exp_t q2[$];
    int   qerr[$];
    exp_t e1, e2;
    exp_t last;

    sif_address_rx #(.MY_ADDR(MY), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst_n), .spi_clk_i(sclk), .spi_data_i(sdat), .mode_i(mode),
        .tx_add_1_o(a1), .tx_add_2_o(b1), .rx_add_o(c1),
        .valid_o(val1), .match_o(mat1), .busy_o(busy1), .err_o(err1)
    );

    sif_address_rx #(.MY_ADDR(MY), .TIMEOUT(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .spi_clk_i(sclk2), .spi_data_i(sdat2), .mode_i(mode2),
        .tx_add_1_o(a2), .tx_add_2_o(b2), .rx_add_o(c2),
        .valid_o(val2), .match_o(mat2), .busy_o(busy2), .err_o(err2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop the expected frame whenever the DUT strobes valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (val1) begin
                if (q1.size() == 0) chk("dut_unexpected_valid", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    chk("dut_tx_add_1", int'(a1), int'(e1.a));
                    chk("dut_tx_add_2", int'(b1), int'(e1.b));
                    chk("dut_rx_add",   int'(c1), int'(e1.c));
                    chk("dut_match",    int'(mat1), int'(e1.m));
                    $display("dut  frame %h/%h/%h match=%0d", a1, b1, c1, mat1);
                end
            end
            if (err1) begin
                if (qerr.size() == 0) chk("dut_unexpected_err", 1, 0);
                else chk("dut_err_cycle", cyc, qerr.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (val2) begin
                if (q2.size() == 0) chk("dut4_unexpected_valid", 1, 0);
                else begin
                    e2 = q2.pop_front();
                    chk("dut4_tx_add_1", int'(a2), int'(e2.a));
                    chk("dut4_tx_add_2", int'(b2), int'(e2.b));
                    chk("dut4_rx_add",   int'(c2), int'(e2.c));
                    chk("dut4_match",    int'(mat2), int'(e2.m));
                    $display("dut4 frame %h/%h/%h match=%0d", a2, b2, c2, mat2);
                end
            end
            if (err2) chk("dut4_race_err", 1, 0);
        end
    end

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit: fall, data change one cycle later, rise, hold high two cycles.
    task automatic send_bit(input bit t, input logic b);
        if (t) sclk2 = 1'b0; else sclk = 1'b0;
        wcyc(1);
        if (t) sdat2 = b; else sdat = b;
        wcyc(1);
        if (t) sclk2 = 1'b1; else sclk = 1'b1;
        wcyc(2);
    endtask

    task automatic send_frame(input bit t, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic m, input int nbits,
                              input bit tog, input bit chkb);
        logic [3:0]  f [3];
        logic [11:0] w;
        exp_t        e;
        f[0] = a; f[1] = b; f[2] = c;
        for (int fi = 0; fi < 3; fi++)
            for (int i = 0; i < 4; i++)
                w[11 - (fi * 4 + i)] = m ? f[fi][i] : f[fi][3 - i];
        if (nbits == 12) begin
            e.a = a; e.b = b; e.c = c; e.m = (c == MY);
            if (t) q2.push_back(e);
            else begin
                q1.push_back(e);
                last = e;
            end
        end
        if (t) mode2 = m; else mode = m;
        for (int k = 0; k < nbits; k++) begin
            send_bit(t, w[11 - k]);
            if (tog && k == 3) begin
                if (t) mode2 = ~mode2; else mode = ~mode;
            end
            if (chkb && k >= 1) chk("busy_in_frame", int'(t ? busy2 : busy1), 1);
        end
    endtask

    logic [11:0] vec [7];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500us");
        $fatal(1);
    end

    initial begin
        vec = '{12'h000, 12'h0FA, 12'h1E5, 12'h2D9, 12'h3C6, 12'h48C, 12'h573};
        last = '{a: 4'h0, b: 4'h0, c: 4'h0, m: 1'b0};
        rst_n = 1'b0;
        sclk = 0; sdat = 0; mode = 0; sclk2 = 0; sdat2 = 0; mode2 = 0;
        wcyc(3);
        rst_n = 1'b1;
        wcyc(5);
        rst_n = 1'b0;
        wcyc(2);
        rst_n = 1'b1;
        wcyc(2);
        chk("rst_tx_add_1", int'(a1), 0);
        chk("rst_tx_add_2", int'(b1), 0);
        chk("rst_rx_add",   int'(c1), 0);
        chk("rst_valid",    int'(val1), 0);
        chk("rst_match",    int'(mat1), 0);
        chk("rst_busy",     int'(busy1), 0);
        chk("rst_err",      int'(err1), 0);

        send_frame(0, 4'h0, 4'hF, 4'hA, 1'b0, 12, 0, 1);
        wcyc(3);
        chk("busy_after_frame", int'(busy1), 0);

        send_frame(0, 4'h1, 4'hE, 4'h5, 1'b1, 12, 0, 0);
        send_frame(0, 4'h1, 4'hE, 4'h5, 1'b1, 12, 1, 0);
        wcyc(4);

        // Timeout: seven bits, then the clock stalls low.
        send_frame(0, 4'h9, 4'h6, 4'h3, 1'b0, 7, 0, 0);
        qerr.push_back(cyc + 65);
        sclk = 1'b0;
        wcyc(72);
        chk("to_busy",      int'(busy1), 0);
        chk("to_keep_a",    int'(a1), int'(last.a));
        chk("to_keep_b",    int'(b1), int'(last.b));
        chk("to_keep_c",    int'(c1), int'(last.c));
        chk("to_keep_m",    int'(mat1), int'(last.m));
        send_frame(0, 4'h3, 4'hC, 4'h6, 1'b0, 12, 0, 0);
        wcyc(4);

        // Reset mid-frame.
        send_frame(0, 4'h7, 4'h2, 4'hB, 1'b0, 5, 0, 0);
        rst_n = 1'b0;
        sclk = 1'b0;
        wcyc(3);
        rst_n = 1'b1;
        wcyc(3);
        chk("midrst_busy", int'(busy1), 0);
        send_frame(0, 4'h4, 4'h8, 4'hC, 1'b0, 12, 0, 0);

        // Back-to-back transmitter vector set on both instances.
        for (int i = 0; i < 7; i++)
            send_frame(0, vec[i][11:8], vec[i][7:4], vec[i][3:0], 1'b0, 12, 0, 0);
        for (int i = 0; i < 7; i++)
            send_frame(1, vec[i][11:8], vec[i][7:4], vec[i][3:0], 1'b0, 12, 0, 1);
        for (int i = 0; i < 3; i++)
            send_frame(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 12, 0, 0);

        // Randomized frames with random gaps and bit order.
        for (int i = 0; i < 10; i++) begin
            send_frame(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       (i % 3 == 0) ? MY : 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 12, 0, 0);
            wcyc($urandom_range(0, 6));
        end

        wcyc(20);
        chk("dut_frames_drained",  q1.size(), 0);
        chk("dut4_frames_drained", q2.size(), 0);
        chk("dut_err_drained",     qerr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
